// File: rtl/present_round_engine.sv
// Iterative PRESENT-80 datapath: one round per cycle using round keys supplied by an external key store.
// Define PRESENT_DECRYPT_EN to add the mode port and the inverse datapath.
`ifndef PRESENT_NUM_ROUNDS
`define PRESENT_NUM_ROUNDS 31
`endif

module present_round_engine #(
  parameter int BLOCK_W    = 64,
  parameter int NUM_ROUNDS = `PRESENT_NUM_ROUNDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
`ifdef PRESENT_DECRYPT_EN
  input  logic               mode,
`endif
  output logic [5:0]         rk_round,
  input  logic [BLOCK_W-1:0] rk_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS);
  localparam logic [5:0] WHITEN_IDX = 6'(NUM_ROUNDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W/4; n++) y[6'(4*n) +: 4] = sbox4(x[6'(4*n) +: 4]);
    return y;
  endfunction

  // Bit i moves to (16*i) mod 63; the top bit stays in place.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W-1; i++) y[6'((16*i) % (BLOCK_W-1))] = x[6'(i)];
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  localparam logic [5:0] DEC_BASE = 6'(NUM_ROUNDS + 2);

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < BLOCK_W/4; n++) y[6'(4*n) +: 4] = inv_sbox4(x[6'(4*n) +: 4]);
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W-1; i++) y[6'(i)] = x[6'((16*i) % (BLOCK_W-1))];
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction
`endif

  state_t             r_state, w_state_nxt;
  logic [BLOCK_W-1:0] r_data, w_data_nxt;
  logic [5:0]         r_round, w_round_nxt;
  logic [BLOCK_W-1:0] r_ct, w_ct_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [5:0]         w_rk_round;
  logic [BLOCK_W-1:0] w_enc_round;
  logic [BLOCK_W-1:0] w_enc_final;

  assign w_enc_round = p_layer(sbox_layer(r_data ^ rk_i));
  assign w_enc_final = r_data ^ rk_i;

`ifdef PRESENT_DECRYPT_EN
  logic               r_mode, w_mode_nxt;
  logic [BLOCK_W-1:0] w_dec_round;

  assign w_dec_round = inv_sbox_layer(inv_p_layer(r_data)) ^ rk_i;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_round_nxt     = r_round;
    w_ct_nxt        = r_ct;
    w_out_valid_nxt = r_out_valid;
    w_rk_round      = '0;
    in_ready        = 1'b0;
    busy            = 1'b0;
`ifdef PRESENT_DECRYPT_EN
    w_mode_nxt      = r_mode;
`endif
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_data_nxt  = plaintext;
          w_round_nxt = 6'd1;
          w_state_nxt = S_RUN;
`ifdef PRESENT_DECRYPT_EN
          w_mode_nxt  = mode;
`endif
        end
      end
      S_RUN: begin
        busy        = 1'b1;
        w_rk_round  = r_round;
        w_data_nxt  = w_enc_round;
`ifdef PRESENT_DECRYPT_EN
        // Decrypt strips the whitening key first, then walks the keys downwards.
        if (r_mode) begin
          if (r_round == 6'd1) begin
            w_rk_round = WHITEN_IDX;
            w_data_nxt = r_data ^ rk_i;
          end else begin
            w_rk_round = DEC_BASE - r_round;
            w_data_nxt = w_dec_round;
          end
        end
`endif
        w_round_nxt = r_round + 6'd1;
        if (r_round == LAST_ROUND) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        busy            = 1'b1;
        w_rk_round      = WHITEN_IDX;
        w_ct_nxt        = w_enc_final;
`ifdef PRESENT_DECRYPT_EN
        // Last inverse round (key 1) lands straight in the output register.
        if (r_mode) begin
          w_rk_round = 6'd1;
          w_ct_nxt   = w_dec_round;
        end
`endif
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_round_nxt     = '0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_round     <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_round     <= w_round_nxt;
      r_ct        <= w_ct_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef PRESENT_DECRYPT_EN
      r_mode      <= w_mode_nxt;
`endif
    end
  end

  assign rk_round   = w_rk_round;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;

endmodule

// File: tb/tb_present_round_engine.sv
// Directed bench for present_round_engine; models the PRESENT-80 key store to feed rk_i.
`timescale 1ns/1ps
module tb_present_round_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] plaintext = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] rk_i, ciphertext;
  logic [5:0]  rk_round;
`ifdef PRESENT_DECRYPT_EN
  logic        mode = 1'b0;
`endif

  logic [63:0] rk_tab [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] SB = 64'h21748FE3DA09B65C;
  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};
  localparam logic [63:0] P0 = 64'h0;
  localparam logic [63:0] P1 = {64{1'b1}};

  always #5 clk = ~clk;

  assign rk_i = rk_tab[rk_round];

  present_round_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
`ifdef PRESENT_DECRYPT_EN
    .mode       (mode),
`endif
    .rk_round   (rk_round),
    .rk_i       (rk_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 0; i < 64; i++) rk_tab[i] = '0;
    for (int i = 1; i <= 32; i++) begin
      rk_tab[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = SB[{k[79:76], 2'b00} +: 4];
      k[19:15] = k[19:15] ^ 5'(i);
    end
  endtask

  task automatic run_block(input logic [79:0] key, input logic [63:0] pt, input logic [63:0] exp,
                           input int hold, input bit dec, input bit poke);
    int cyc;
    int bad_rk;
    int bad_flag;
    int bad_hold;
    logic [5:0] exp_rk;
    load_keys(key);
    @(negedge clk);
    check("ready_idle", {63'd0, in_ready}, 64'd1);
    plaintext = pt;
    in_valid  = 1'b1;
`ifdef PRESENT_DECRYPT_EN
    mode      = dec;
`endif
    @(negedge clk);
    in_valid  = 1'b0;
    plaintext = ~pt;
    cyc = 1; bad_rk = 0; bad_flag = 0;
    while (!out_valid && cyc < 100) begin
      exp_rk = dec ? 6'(33 - cyc) : 6'(cyc);
      if (rk_round !== exp_rk) bad_rk++;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad_flag++;
      in_valid = (poke && cyc >= 5 && cyc < 8);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'd33);
    check("result", ciphertext, exp);
    check("rk_seq_errs", 64'(bad_rk), 64'd0);
    check("run_flag_errs", 64'(bad_flag), 64'd0);
    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (ciphertext !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad_hold++;
    end
    if (hold > 0) check("hold_errs", 64'(bad_hold), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_accept_ovalid", {63'd0, out_valid}, 64'd0);
    check("post_accept_inready", {63'd0, in_ready}, 64'd1);
    check("post_accept_rk", {58'd0, rk_round}, 64'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) rk_tab[i] = '0;
    #12;
    check("rst_ovalid", {63'd0, out_valid}, 64'd0);
    check("rst_ct", ciphertext, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rk", {58'd0, rk_round}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_inready", {63'd0, in_ready}, 64'd1);

    run_block(K0, P0, 64'h5579C1387B228445, 0, 1'b0, 1'b0);
    run_block(K1, P0, 64'hE72C46C0F5945049, 0, 1'b0, 1'b1);
    run_block(K0, P1, 64'hA112FFC72F68417B, 0, 1'b0, 1'b0);
    run_block(K1, P1, 64'h3333DCD3213210D2, 10, 1'b0, 1'b0);

    // Abort a block mid-flight with an asynchronous reset.
    load_keys(K1);
    @(negedge clk);
    plaintext = P1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    cyc = 0;
    while (rk_round !== 6'd15 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_round15", {58'd0, rk_round}, 64'd15);
    rst_n = 1'b0;
    #1;
    check("abort_ovalid", {63'd0, out_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_rk", {58'd0, rk_round}, 64'd0);
    check("abort_ct", ciphertext, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_inready", {63'd0, in_ready}, 64'd1);
    run_block(K0, P0, 64'h5579C1387B228445, 0, 1'b0, 1'b0);

`ifdef PRESENT_DECRYPT_EN
    run_block(K0, 64'h5579C1387B228445, P0, 0, 1'b1, 1'b0);
    run_block(K1, 64'h3333DCD3213210D2, P1, 0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
